// File: rtl/ub_banked_buffer.sv
// rtl/ub_banked_buffer.sv - banked unified buffer with byte masks, pipelined reads and bulk clear
// Optional macro UB_WR_BYPASS_EN: same-address read during a write returns the merged word.
module ub_banked_buffer #(
    parameter  int DATA_W     = 64,
    parameter  int BANK_DEPTH = 4096,
    parameter  int NUM_BANKS  = 8,
    parameter  int RD_LATENCY = 2,
    localparam int MASK_W     = DATA_W / 8,
    localparam int IDX_W      = $clog2(BANK_DEPTH),
    localparam int BSEL_W     = $clog2(NUM_BANKS),
    localparam int ADDR_W     = BSEL_W + IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [MASK_W-1:0] wr_mask_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              clr_start_i,
    output logic              clr_busy_o,
    output logic              drop_o
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               idle;

    logic [BSEL_W-1:0]  wr_bank, rd_bank;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               wr_fire, rd_fire;

    logic [DATA_W-1:0]  bank_rd [NUM_BANKS];
    logic [RD_LATENCY:0] vld_q;
    logic [BSEL_W-1:0]  bsel_q;
    logic [DATA_W-1:0]  dat_q [RD_LATENCY];
    logic               drop_q;

    assign wr_bank = wr_addr_i[ADDR_W-1:IDX_W];
    assign wr_idx  = wr_addr_i[IDX_W-1:0];
    assign rd_bank = rd_addr_i[ADDR_W-1:IDX_W];
    assign rd_idx  = rd_addr_i[IDX_W-1:0];
    assign wr_fire = wr_en_i & idle;
    assign rd_fire = rd_en_i & idle;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // The counter rolls over to zero on the exit edge, so IDLE always sees it cleared.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start_i) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {IDX_W{1'b1}}) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idle       = (state_q == S_IDLE);
        clr_busy_o = (state_q == S_CLEAR);
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [BANK_DEPTH];
        logic [DATA_W-1:0] rd_q;
        logic [DATA_W-1:0] rd_word;
        logic              we;
        logic              re;
        logic [IDX_W-1:0]  widx;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;

        always_comb begin
            we    = 1'b0;
            widx  = wr_idx;
            wdata = wr_data_i;
            wmask = wr_mask_i;
            if (clr_busy_o) begin
                we    = 1'b1;
                widx  = clr_cnt_q;
                wdata = '0;
                wmask = '1;
            end else if (wr_fire && (wr_bank == BSEL_W'(b))) begin
                we = 1'b1;
            end
            re = rd_fire && (rd_bank == BSEL_W'(b));
        end

        always_comb begin
            rd_word = mem[rd_idx];
`ifdef UB_WR_BYPASS_EN
            for (int k = 0; k < MASK_W; k++) begin
                if (wr_fire && (wr_bank == BSEL_W'(b)) && (wr_idx == rd_idx) && wr_mask_i[k])
                    rd_word[8*k +: 8] = wr_data_i[8*k +: 8];
            end
`endif
        end

        always_ff @(posedge clk_i) begin
            for (int k = 0; k < MASK_W; k++) begin
                if (we && wmask[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
            end
            if (re) rd_q <= rd_word;
        end

        assign bank_rd[b] = rd_q;
    end

    // Data stages only advance with their valid bit, so the output holds between reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            bsel_q <= '0;
            drop_q <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q  <= {vld_q[RD_LATENCY-1:0], rd_fire};
            drop_q <= clr_busy_o & (wr_en_i | rd_en_i);
            if (rd_fire) bsel_q <= rd_bank;
            if (vld_q[0]) dat_q[0] <= bank_rd[bsel_q];
            for (int i = 1; i < RD_LATENCY; i++) begin
                if (vld_q[i]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign rd_data_o  = dat_q[RD_LATENCY-1];
    assign rd_valid_o = vld_q[RD_LATENCY];
    assign drop_o     = drop_q;

endmodule

// File: doc/ub_banked_buffer.md
Name: ub_banked_buffer

Overview:
Parametrised unified buffer built from NUM_BANKS single-clock memory banks, each with one write port and one read port.
- The upper address bits select the bank; the lower bits index within the bank.
- Adds over the previous generation: per-byte write masks, a pipelined read path with a valid flag, a hardware bulk-clear state machine, and request-drop reporting.
- Sits between the host DMA and the systolic-array activation/result datapath of the TPU.

Parameters:
DATA_W, 64, word width in bits; must be a multiple of 8.
BANK_DEPTH, 4096, words per bank; must be a power of two.
NUM_BANKS, 8, bank count; must be a power of two, at least 2.
RD_LATENCY, 2, cycles from accepted read to rd_valid_o; must be at least 1.
Derived: MASK_W = DATA_W/8; IDX_W = $clog2(BANK_DEPTH); BSEL_W = $clog2(NUM_BANKS); ADDR_W = BSEL_W + IDX_W.

Ports:
clk_i  input  1  clock; all logic is rising-edge.
rst_i  input  1  reset, asynchronous, active-high.
wr_en_i  input  1  write request.
wr_addr_i  input  ADDR_W  write address; [ADDR_W-1:IDX_W] selects the bank, [IDX_W-1:0] is the index.
wr_data_i  input  DATA_W  write data.
wr_mask_i  input  MASK_W  byte enables; bit k enables byte k.
rd_en_i  input  1  read request.
rd_addr_i  input  ADDR_W  read address; same split as wr_addr_i.
rd_data_o  output  DATA_W  read data.
rd_valid_o  output  1  one-cycle pulse marking rd_data_o valid.
clr_start_i  input  1  starts a bulk clear of all banks.
clr_busy_o  output  1  high while a clear is in progress.
drop_o  output  1  one-cycle pulse: a request arrived during a clear and was discarded.

Behaviour:
- Reset values: rd_data_o = 0, rd_valid_o = 0, clr_busy_o = 0, drop_o = 0, FSM in IDLE, read pipeline valid bits cleared. Memory contents are not reset.
- Write: if wr_en_i is high in IDLE, then at the clock edge, for every k with wr_mask_i[k] = 1, byte k of bank[wr_addr_i bank field][index] is updated. Only the addressed bank is enabled. A write with an all-zero mask changes nothing.
- Read: if rd_en_i is high in IDLE, the addressed bank is read at that edge. The bank select is pipelined alongside the data for the output mux. rd_data_o and rd_valid_o are updated exactly RD_LATENCY edges later.
- Reads are fully pipelined: one read per cycle, back-to-back, across any banks.
- rd_data_o holds its last valid value while rd_valid_o is low.
- Same-cycle read and write to the same address: read-first, the read returns the old word (see Optional Feature). Same-cycle read and write to different banks or indices: both proceed independently.
- FSM states:
  - IDLE: clr_start_i = 1 causes a transition to CLEAR, with clr_busy_o = 1 from the next cycle and the clear index counter = 0. Writes and reads at this same edge are still serviced.
  - CLEAR: each cycle, all banks write zero at the counter index in parallel and the counter increments. Exit to IDLE after the edge that writes index BANK_DEPTH-1. clr_busy_o falls in the following cycle; the clear takes exactly BANK_DEPTH busy cycles.
- Requests during CLEAR: wr_en_i, rd_en_i and clr_start_i are ignored. drop_o pulses for one cycle, one cycle after any ignored wr_en_i or rd_en_i. Reads already in the pipeline when CLEAR begins complete normally.
- Reset during CLEAR: the clear aborts and the FSM returns to IDLE. Memory is left partially cleared; nothing is guaranteed about its contents.
- Address arithmetic: the counter width is IDX_W and it does not wrap during CLEAR. All addresses are in range by construction, so no out-of-bounds case exists.

Optional Feature:
Macro UB_WR_BYPASS_EN.
- Defined: on a same-cycle read and write to the same address, the read returns the merged word (new bytes where wr_mask_i = 1, old bytes elsewhere). Latency is unchanged.
- Undefined: read-first behaviour, old word returned. No bypass logic is synthesised.

Test Plan:
- Write 0x1122334455667788 at address 0x0005 with mask 0xFF; read 0x0005 on the next cycle -> rd_valid_o high 2 cycles later, rd_data_o = 0x1122334455667788.
- After the above, write 0xAAAAAAAAAAAAAAAA at 0x0005 with mask 0x0F; read -> 0x11223344AAAAAAAA.
- Write distinct values at 0x0FFF (bank 0, last index) and 0x1000 (bank 1, index 0); back-to-back reads -> both values returned in order on consecutive valid cycles.
- Same-cycle write of 0xFFFFFFFFFFFFFFFF (mask 0xFF) and read at 0x0005 -> 0x11223344AAAAAAAA without the macro, 0xFFFFFFFFFFFFFFFF with UB_WR_BYPASS_EN.
- Pulse clr_start_i, then issue a write at busy cycle 10 -> clr_busy_o high for exactly 4096 cycles, drop_o pulses once; afterwards reads of 0x0005, 0x1000 and 0x7FFF all return 0.
- Start a clear, assert rst_i at busy cycle 100 -> clr_busy_o = 0, rd_valid_o = 0 immediately; after release a new clr_start_i completes a full 4096-cycle clear.
